ir_cursor_controller: RTL and testbench

Sequences cursor movement for the VGA display from the decoded IR remote directions. Takes the level-type Up/Down/Left/Right/Readable outputs of the IR input chain and applies one step per command to an on-screen X/Y position. Updates happen only at frame start (vertical blank), so the renderer never sees a mid-frame change. Holding a button auto-repeats at a fixed frame rate, and the position is clamped to the visible area.

---
 rtl/ir_cursor_controller.sv | 171 +++++++++++++++++
 tb/tb_ir_cursor_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ir_cursor_controller.sv
// ir_cursor_controller
//   Applies decoded IR remote direction commands to an on-screen cursor.
//   Moves are committed only at frame start, and a held button
//   auto-repeats every REPEAT_FRAMES frames. The position saturates at
//   the edges of the visible area.
//
// Ports
//   i_clk          system/pixel clock (only clock)
//   i_rst          synchronous, active-high reset
//   i_up/i_down/i_left/i_right  direction levels from the IR decoder (async)
//   i_readable     direction levels valid while high (async)
//   i_frame_start  one-cycle pulse at start of vertical blank (i_clk domain)
//   o_pos_x/o_pos_y current cursor position
//   o_update       one-cycle pulse when the position actually changed
//   o_moving       high whenever the sequencer is not idle
module ir_cursor_controller #(
    parameter int H_MAX         = 640,
    parameter int V_MAX         = 480,
    parameter int STEP          = 4,
    parameter int REPEAT_FRAMES = 8,
    parameter int X_INIT        = 320,
    parameter int Y_INIT        = 240,
    parameter int XY_W          = 10
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_up,
    input  logic            i_down,
    input  logic            i_left,
    input  logic            i_right,
    input  logic            i_readable,
    input  logic            i_frame_start,
    output logic [XY_W-1:0] o_pos_x,
    output logic [XY_W-1:0] o_pos_y,
    output logic            o_update,
    output logic            o_moving
);

    localparam int CNT_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REPEAT_FRAMES - 1);

    // Coordinates are widened by one bit so p+STEP cannot wrap before the clamp.
    localparam logic [XY_W:0] STEP_E = (XY_W + 1)'(STEP);
    localparam logic [XY_W:0] XMAX_E = (XY_W + 1)'(H_MAX - 1);
    localparam logic [XY_W:0] YMAX_E = (XY_W + 1)'(V_MAX - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        APPLY,
        HOLD
    } state_t;

    state_t           r_state;
    logic [4:0]       r_sync1;
    logic [4:0]       r_sync2;
    logic [3:0]       r_pend;     // {dx[1:0], dy[1:0]}, each 01=+1, 11=-1, 00=0
    logic [CNT_W-1:0] r_cnt;
    logic [XY_W-1:0]  r_pos_x;
    logic [XY_W-1:0]  r_pos_y;
    logic             r_update;
    logic             r_moving;

    logic             w_up, w_down, w_left, w_right, w_rd;
    logic [1:0]       w_dx, w_dy;
    logic [3:0]       w_vec;
    logic             w_active;
    logic [XY_W:0]    w_x_ext, w_y_ext, w_x_new, w_y_new;
    logic             w_changed;

    // Synchronized order: {readable, up, down, left, right}
    assign w_rd    = r_sync2[4];
    assign w_up    = r_sync2[3];
    assign w_down  = r_sync2[2];
    assign w_left  = r_sync2[1];
    assign w_right = r_sync2[0];

    always_comb begin
        w_dx = 2'b00;
        w_dy = 2'b00;
        if (w_right && !w_left)      w_dx = 2'b01;
        else if (w_left && !w_right) w_dx = 2'b11;
        if (w_down && !w_up)         w_dy = 2'b01;
        else if (w_up && !w_down)    w_dy = 2'b11;
    end

    assign w_vec    = {w_dx, w_dy};
    assign w_active = w_rd && (w_vec != 4'b0000);

    // Saturating next position from the pending vector.
    always_comb begin
        w_x_ext = {1'b0, r_pos_x};
        w_y_ext = {1'b0, r_pos_y};
        w_x_new = w_x_ext;
        w_y_new = w_y_ext;
        case (r_pend[3:2])
            2'b01:   w_x_new = (w_x_ext + STEP_E <= XMAX_E) ? w_x_ext + STEP_E : XMAX_E;
            2'b11:   w_x_new = (w_x_ext >= STEP_E) ? w_x_ext - STEP_E : '0;
            default: w_x_new = w_x_ext;
        endcase
        case (r_pend[1:0])
            2'b01:   w_y_new = (w_y_ext + STEP_E <= YMAX_E) ? w_y_ext + STEP_E : YMAX_E;
            2'b11:   w_y_new = (w_y_ext >= STEP_E) ? w_y_ext - STEP_E : '0;
            default: w_y_new = w_y_ext;
        endcase
    end

    assign w_changed = (w_x_new != w_x_ext) || (w_y_new != w_y_ext);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_pend   <= '0;
            r_cnt    <= '0;
            r_pos_x  <= XY_W'(X_INIT);
            r_pos_y  <= XY_W'(Y_INIT);
            r_update <= 1'b0;
            r_moving <= 1'b0;
        end else begin
            r_sync1  <= {i_readable, i_up, i_down, i_left, i_right};
            r_sync2  <= r_sync1;
            r_update <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A Frame_Start in this same cycle is deliberately not consumed.
                    if (w_active) begin
                        r_pend   <= w_vec;
                        r_state  <= ARMED;
                        r_moving <= 1'b1;
                    end
                end
                ARMED: begin
                    // Release does not cancel: a short tap always yields one move.
                    if (w_active && (w_vec != r_pend)) r_pend <= w_vec;
                    if (i_frame_start) r_state <= APPLY;
                end
                APPLY: begin
                    r_pos_x  <= w_x_new[XY_W-1:0];
                    r_pos_y  <= w_y_new[XY_W-1:0];
                    r_update <= w_changed;
                    r_cnt    <= CNT_RELOAD;
                    r_state  <= HOLD;
                end
                HOLD: begin
                    if (!w_active) begin
                        r_state  <= IDLE;
                        r_moving <= 1'b0;
                    end else if (w_vec != r_pend) begin
                        r_pend  <= w_vec;
                        r_state <= ARMED;
                    end else if (i_frame_start) begin
                        if (r_cnt == '0) r_state <= APPLY;
                        else             r_cnt   <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_moving <= 1'b0;
                end
            endcase
        end
    end

    assign o_pos_x  = r_pos_x;
    assign o_pos_y  = r_pos_y;
    assign o_update = r_update;
    assign o_moving = r_moving;

endmodule

// File: tb/tb_ir_cursor_controller.sv
module tb_ir_cursor_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, rd = 1'b0, fs = 1'b0;
    logic [9:0] px, py, bx, by;
    logic       upd, mov, bupd, bmov;

    int passes = 0;
    int total  = 0;
    int upd_cnt = 0, mov_cnt = 0, bupd_cnt = 0;

    always #5 clk = ~clk;

    ir_cursor_controller dut (
        .i_clk(clk), .i_rst(rst), .i_up(up), .i_down(down), .i_left(left),
        .i_right(right), .i_readable(rd), .i_frame_start(fs),
        .o_pos_x(px), .o_pos_y(py), .o_update(upd), .o_moving(mov)
    );

    // Second instance started near the edges for saturation checks.
    ir_cursor_controller #(.X_INIT(2), .Y_INIT(478)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_up(up), .i_down(down), .i_left(left),
        .i_right(right), .i_readable(rd), .i_frame_start(fs),
        .o_pos_x(bx), .o_pos_y(by), .o_update(bupd), .o_moving(bmov)
    );

    always @(posedge clk) begin
        if (upd)  upd_cnt++;
        if (mov)  mov_cnt++;
        if (bupd) bupd_cnt++;
    end

    typedef struct {
        logic u, d, l, r, rdy;
        int   ex, ey, eupd, emov;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        {up, down, left, right, rd, fs} = '0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic pulse_fs();
        fs = 1'b1;
        tick();
        fs = 1'b0;
    endtask

    task automatic tap(input logic u, input logic d, input logic l, input logic r, input logic rdy);
        {up, down, left, right, rd} = {u, d, l, r, rdy};
        tick(3);
        {up, down, left, right, rd} = '0;
        tick(20);
        pulse_fs();
        tick(6);
    endtask

    initial begin
        int u0, m0, b0;

        //         u  d  l  r  rd   x    y    upd mov
        vecs[0] = '{0, 0, 0, 1, 1, 324, 240, 1, 1};
        vecs[1] = '{0, 0, 1, 0, 1, 316, 240, 1, 1};
        vecs[2] = '{1, 0, 0, 0, 1, 320, 236, 1, 1};
        vecs[3] = '{0, 1, 0, 0, 1, 320, 244, 1, 1};
        vecs[4] = '{1, 0, 0, 1, 1, 324, 236, 1, 1};
        vecs[5] = '{0, 1, 1, 0, 1, 316, 244, 1, 1};
        vecs[6] = '{1, 1, 0, 0, 1, 320, 240, 0, 0};
        vecs[7] = '{1, 1, 0, 1, 1, 324, 240, 1, 1};
        vecs[8] = '{0, 0, 0, 1, 0, 320, 240, 0, 0};
        vecs[9] = '{1, 1, 1, 1, 1, 320, 240, 0, 0};

        // Reset state and idle stability
        do_reset();
        check("reset_x", px, 320);
        check("reset_y", py, 240);
        check("reset_upd", upd, 0);
        check("reset_mov", mov, 0);
        u0 = upd_cnt;
        tick(100);
        check("idle_x", px, 320);
        check("idle_y", py, 240);
        check("idle_upd_cnt", upd_cnt - u0, 0);

        // Table: single taps, each followed by a second frame that must not move
        for (int i = 0; i < 10; i++) begin
            do_reset();
            u0 = upd_cnt;
            m0 = mov_cnt;
            tap(vecs[i].u, vecs[i].d, vecs[i].l, vecs[i].r, vecs[i].rdy);
            pulse_fs();
            tick(6);
            check($sformatf("v%0d_x", i), px, vecs[i].ex);
            check($sformatf("v%0d_y", i), py, vecs[i].ey);
            check($sformatf("v%0d_upd_cnt", i), upd_cnt - u0, vecs[i].eupd);
            check($sformatf("v%0d_mov_seen", i), (mov_cnt - m0) > 0 ? 1 : 0, vecs[i].emov);
            check($sformatf("v%0d_mov_end", i), mov, 0);
        end

        // Exact latency of a tap
        do_reset();
        {right, rd} = 2'b11;
        tick(3);
        {right, rd} = 2'b00;
        tick(20);
        fs = 1'b1;
        tick();
        fs = 1'b0;
        check("lat_apply_x", px, 320);
        check("lat_apply_upd", upd, 0);
        check("lat_apply_mov", mov, 1);
        tick();
        check("lat_move_x", px, 324);
        check("lat_move_upd", upd, 1);
        tick();
        check("lat_upd_fall", upd, 0);
        tick(3);
        check("lat_mov_end", mov, 0);

        // Frame_Start coincident with the latch cycle is not consumed
        do_reset();
        {right, rd} = 2'b11;
        tick(2);
        fs = 1'b1;
        tick();
        fs = 1'b0;
        tick();
        {right, rd} = 2'b00;
        tick(10);
        check("latchfs_x_held", px, 320);
        check("latchfs_mov", mov, 1);
        pulse_fs();
        tick(3);
        check("latchfs_x_moved", px, 324);

        // Held Up: moves at pulses 1, 9, 17
        do_reset();
        u0 = upd_cnt;
        {up, rd} = 2'b11;
        tick(10);
        for (int k = 1; k <= 20; k++) begin
            pulse_fs();
            tick(5);
            check($sformatf("hold_y_p%0d", k), py, 240 - 4 * ((k - 1) / 8 + 1));
        end
        check("hold_upd_cnt", upd_cnt - u0, 3);
        {up, rd} = 2'b00;
        tick(6);
        check("hold_mov_end", mov, 0);

        // Saturation on the edge-initialised instance
        do_reset();
        b0 = bupd_cnt;
        tap(0, 0, 1, 0, 1);
        check("sat_left_x", bx, 0);
        check("sat_left_upd", bupd_cnt - b0, 1);
        b0 = bupd_cnt;
        tap(0, 0, 1, 0, 1);
        check("sat_left2_x", bx, 0);
        check("sat_left2_upd", bupd_cnt - b0, 0);
        check("sat_left2_mov", bmov, 0);
        b0 = bupd_cnt;
        tap(0, 1, 0, 0, 1);
        check("sat_down_y", by, 479);
        check("sat_down_upd", bupd_cnt - b0, 1);
        b0 = bupd_cnt;
        tap(0, 1, 0, 0, 1);
        check("sat_down2_y", by, 479);
        check("sat_down2_upd", bupd_cnt - b0, 0);

        // Reset in HOLD coincident with the Frame_Start that would apply
        do_reset();
        {right, rd} = 2'b11;
        tick(10);
        for (int k = 1; k <= 16; k++) begin
            pulse_fs();
            tick(5);
        end
        check("rsth_x_before", px, 328);
        u0 = upd_cnt;
        rst = 1'b1;
        fs  = 1'b1;
        tick();
        fs  = 1'b0;
        tick();
        rst = 1'b0;
        check("rsth_x", px, 320);
        check("rsth_y", py, 240);
        check("rsth_mov", mov, 0);
        tick(2);
        check("rsth_upd_cnt", upd_cnt - u0, 0);
        tick(2);
        check("rsth_rearm_mov", mov, 1);
        pulse_fs();
        tick(3);
        check("rsth_rearm_x", px, 324);
        {right, rd} = 2'b00;
        tick(5);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
